// File: rtl/fp_mul_add_sequencer.sv
// Sequences FP mul/add ops (incl. fused forms) over an external multi-cycle mul-add unit.
// Optional perf counters are enabled by defining FP_MUL_ADD_SEQUENCER_PERF_COUNT_EN.
module fp_mul_add_sequencer #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int FRACTION_WIDTH = 23,
    parameter int WIDTH          = 1 + EXPONENT_WIDTH + FRACTION_WIDTH,
    parameter int UNIT_LATENCY   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_src1,
    input  logic [WIDTH-1:0] req_src2,
    input  logic [WIDTH-1:0] req_src3,
    input  logic [2:0]       req_rounding_mode,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic [4:0]       resp_flags,
    output logic [1:0]       unit_command,
    output logic [WIDTH-1:0] unit_src1,
    output logic [WIDTH-1:0] unit_src2,
    output logic [2:0]       unit_rounding_mode,
    input  logic [WIDTH-1:0] unit_result,
    input  logic [4:0]       unit_flags
`ifdef FP_MUL_ADD_SEQUENCER_PERF_COUNT_EN
    ,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_busy
`endif
);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

    localparam int              CNT_W     = (UNIT_LATENCY > 1) ? $clog2(UNIT_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(UNIT_LATENCY - 1);
    localparam logic [WIDTH-1:0] CANON_NAN =
        {1'b0, {EXPONENT_WIDTH{1'b1}}, 1'b1, {(FRACTION_WIDTH-1){1'b0}}};

    localparam logic [1:0] CMD_MUL = 2'd0;
    localparam logic [1:0] CMD_ADD = 2'd1;
    localparam logic [1:0] CMD_SUB = 2'd2;

    localparam logic [2:0] OP_FADD   = 3'd1;
    localparam logic [2:0] OP_FSUB   = 3'd2;
    localparam logic [2:0] OP_FMADD  = 3'd3;
    localparam logic [2:0] OP_FNMSUB = 3'd5;
    localparam logic [2:0] OP_FNMADD = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [2:0]       rm_q, rm_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       flags_q, flags_d;

    logic last_cycle;
    logic two_pass;
    logic negate_p;

    assign last_cycle = (cnt_q == '0);
    assign two_pass   = (op_q >= OP_FMADD) && (op_q != OP_RSVD);
    assign negate_p   = (op_q == OP_FNMSUB) || (op_q == OP_FNMADD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            rm_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            rm_q     <= rm_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = (req_op == OP_RSVD) ? RESP : PASS1;
            PASS1:   if (last_cycle) state_d = two_pass ? PASS2 : RESP;
            PASS2:   if (last_cycle) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // result_q doubles as the PASS1 product p feeding PASS2, then as the final result.
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        rm_d     = rm_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d = req_op;
                    a_d  = req_src1;
                    b_d  = req_src2;
                    c_d  = req_src3;
                    rm_d = req_rounding_mode;
                    if (req_op == OP_RSVD) begin
                        result_d = CANON_NAN;
                        flags_d  = 5'b10000;
                    end else begin
                        cnt_d    = CNT_LOAD;
                        result_d = '0;
                        flags_d  = '0;
                    end
                end
            end
            PASS1, PASS2: begin
                if (last_cycle) begin
                    result_d = unit_result;
                    flags_d  = flags_q | unit_flags;
                    cnt_d    = ((state_q == PASS1) && two_pass) ? CNT_LOAD : '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready          = (state_q == IDLE);
        resp_valid         = (state_q == RESP);
        resp_result        = result_q;
        resp_flags         = flags_q;
        unit_rounding_mode = rm_q;
        unit_command       = CMD_MUL;
        unit_src1          = '0;
        unit_src2          = '0;
        case (state_q)
            PASS1: begin
                unit_src1 = a_q;
                unit_src2 = b_q;
                if (op_q == OP_FADD)      unit_command = CMD_ADD;
                else if (op_q == OP_FSUB) unit_command = CMD_SUB;
                else                      unit_command = CMD_MUL;
            end
            PASS2: begin
                unit_src1    = negate_p ? {~result_q[WIDTH-1], result_q[WIDTH-2:0]} : result_q;
                unit_src2    = c_q;
                unit_command = ((op_q == OP_FMADD) || (op_q == OP_FNMSUB)) ? CMD_ADD : CMD_SUB;
            end
            default: ;
        endcase
    end

`ifdef FP_MUL_ADD_SEQUENCER_PERF_COUNT_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_busy_q, perf_busy_d;

    always_comb begin
        perf_ops_d  = perf_ops_q;
        perf_busy_d = perf_busy_q;
        if ((state_q == RESP) && resp_ready) perf_ops_d = perf_ops_q + 32'd1;
        if (state_q != IDLE) perf_busy_d = perf_busy_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_q  <= '0;
            perf_busy_q <= '0;
        end else begin
            perf_ops_q  <= perf_ops_d;
            perf_busy_q <= perf_busy_d;
        end
    end

    assign perf_ops  = perf_ops_q;
    assign perf_busy = perf_busy_q;
`endif

endmodule

// File: tb/tb_fp_mul_add_sequencer.sv
// Bench for fp_mul_add_sequencer: behavioural single-precision unit with latency checking,
// table vectors, handshake/reset corner sequences and randomized ops against a reference model.
module tb_fp_mul_add_sequencer;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_src1, req_src2, req_src3;
    logic [2:0]  req_rounding_mode;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [4:0]  resp_flags;
    logic [1:0]  unit_command;
    logic [31:0] unit_src1, unit_src2;
    logic [2:0]  unit_rounding_mode;
    logic [31:0] unit_result;
    logic [4:0]  unit_flags;
`ifdef FP_MUL_ADD_SEQUENCER_PERF_COUNT_EN
    logic [31:0] perf_ops, perf_busy;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    fp_mul_add_sequencer #(.UNIT_LATENCY(L)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_op             (req_op),
        .req_src1           (req_src1),
        .req_src2           (req_src2),
        .req_src3           (req_src3),
        .req_rounding_mode  (req_rounding_mode),
        .resp_valid         (resp_valid),
        .resp_ready         (resp_ready),
        .resp_result        (resp_result),
        .resp_flags         (resp_flags),
        .unit_command       (unit_command),
        .unit_src1          (unit_src1),
        .unit_src2          (unit_src2),
        .unit_rounding_mode (unit_rounding_mode),
        .unit_result        (unit_result),
        .unit_flags         (unit_flags)
`ifdef FP_MUL_ADD_SEQUENCER_PERF_COUNT_EN
        ,
        .perf_ops           (perf_ops),
        .perf_busy          (perf_busy)
`endif
    );

    always #5 clk = ~clk;

    // Single-precision arithmetic via doubles; denormals flush to zero, rounding truncates.
    function automatic real to_real(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'd0) return 0.0;
        e = 11'(x[30:23]) + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'b0});
    endfunction

    function automatic logic [36:0] from_real(input real r);
        logic [63:0] bits;
        int          se;
        bits = $realtobits(r);
        if (bits[62:52] == 11'd0) return {5'b00000, bits[63], 31'b0};
        se = int'(bits[62:52]) - 1023 + 127;
        if (se >= 255) return {5'b00101, bits[63], 8'hFF, 23'b0};
        if (se <= 0)   return {5'b00011, bits[63], 31'b0};
        return {4'b0000, |bits[28:0], bits[63], se[7:0], bits[51:29]};
    endfunction

    function automatic logic [36:0] fp_unit(input logic [1:0] cmd, input logic [31:0] x, input logic [31:0] y);
        real r;
        case (cmd)
            2'd0:    r = to_real(x) * to_real(y);
            2'd1:    r = to_real(x) + to_real(y);
            2'd2:    r = to_real(x) - to_real(y);
            default: r = 0.0;
        endcase
        return from_real(r);
    endfunction

    // Expected {flags, result} of a whole operation, straight from the op definitions.
    function automatic logic [36:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c);
        logic [36:0] p, q;
        logic [31:0] pv;
        case (op)
            3'd0: return fp_unit(2'd0, a, b);
            3'd1: return fp_unit(2'd1, a, b);
            3'd2: return fp_unit(2'd2, a, b);
            3'd7: return {5'b10000, 32'h7FC00000};
            default: begin
                p  = fp_unit(2'd0, a, b);
                pv = p[31:0];
                if (op == 3'd5 || op == 3'd6) pv[31] = ~pv[31];
                q = fp_unit((op == 3'd3 || op == 3'd5) ? 2'd1 : 2'd2, pv, c);
                return {p[36:32] | q[36:32], q[31:0]};
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op);
        if (op == 3'd7) return 1;
        if (op <= 3'd2) return 1 + L;
        return 1 + 2 * L;
    endfunction

    // Unit model only returns a valid answer on the L-th cycle of stable inputs.
    logic [1:0]  prev_cmd_q;
    logic [31:0] prev_s1_q, prev_s2_q;
    int          age_q = 0;
    int          age_now;

    always_comb begin
        age_now = 0;
        if (unit_command == prev_cmd_q && unit_src1 == prev_s1_q && unit_src2 == prev_s2_q)
            age_now = age_q + 1;
    end

    always @(posedge clk) begin
        prev_cmd_q <= unit_command;
        prev_s1_q  <= unit_src1;
        prev_s2_q  <= unit_src2;
        age_q      <= age_now;
    end

    always_comb begin
        unit_result = 32'hDEADBEEF;
        unit_flags  = 5'h1F;
        if (age_now == L - 1) {unit_flags, unit_result} = fp_unit(unit_command, unit_src1, unit_src2);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Waits for idle, issues one request, then scrambles inputs and waits for resp_valid.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [2:0] rm, output int lat);
        int waited = 0;
        while (!req_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("req_ready before accept", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op = op; req_src1 = a; req_src2 = b; req_src3 = c; req_rounding_mode = rm;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 3'($urandom); req_src1 = $urandom; req_src2 = $urandom; req_src3 = $urandom;
        req_rounding_mode = 3'($urandom);
        checkOutput("latched rounding mode", 32'(unit_rounding_mode), 32'(rm));
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic runVector(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] c,
                             input logic [31:0] exp_res, input logic [4:0] exp_flags, input int exp_lat);
        int lat;
        applyStimulus(op, a, b, c, 3'($urandom), lat);
        checkOutput({name, " latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({name, " result"}, resp_result, exp_res);
        checkOutput({name, " flags"}, 32'(resp_flags), 32'(exp_flags));
        @(posedge clk); #1;
        checkOutput({name, " resp_valid after consume"}, 32'(resp_valid), 32'd0);
    endtask

    function automatic logic [31:0] rand_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, c;
        logic [31:0] res;
        logic [4:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        automatic int          lat;
        automatic logic [31:0] held;
        automatic logic [36:0] expv;
        automatic logic [2:0]  rop;
        automatic logic [31:0] ra, rb, rc;
        automatic int          seen;

        vecs[0] = '{3'd3, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h40E00000, 5'b00000, 5};
        vecs[1] = '{3'd6, 32'h40000000, 32'h40400000, 32'h3F800000, 32'hC0E00000, 5'b00000, 5};
        vecs[2] = '{3'd0, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h40C00000, 5'b00000, 3};
        vecs[3] = '{3'd1, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h40A00000, 5'b00000, 3};
        vecs[4] = '{3'd2, 32'h40000000, 32'h40400000, 32'h3F800000, 32'hBF800000, 5'b00000, 3};
        vecs[5] = '{3'd4, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h40A00000, 5'b00000, 5};
        vecs[6] = '{3'd5, 32'h40000000, 32'h40400000, 32'h3F800000, 32'hC0A00000, 5'b00000, 5};
        vecs[7] = '{3'd7, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h7FC00000, 5'b10000, 1};
        vecs[8] = '{3'd3, 32'h3F800001, 32'h3F800001, 32'h3F800000, 32'h40000001, 5'b00001, 5};

        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
        req_op = '0; req_src1 = '0; req_src2 = '0; req_src3 = '0; req_rounding_mode = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset resp_result", resp_result, 32'd0);
        checkOutput("reset resp_flags", 32'(resp_flags), 32'd0);
        checkOutput("reset unit_command", 32'(unit_command), 32'd0);
        checkOutput("reset unit_src1", unit_src1, 32'd0);
        checkOutput("reset unit_rounding_mode", 32'(unit_rounding_mode), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            runVector($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c,
                      vecs[i].res, vecs[i].flags, vecs[i].lat);

        // Backpressure: response must hold while resp_ready is low and new requests are ignored.
        resp_ready = 1'b0;
        applyStimulus(3'd0, 32'h40000000, 32'h40400000, 32'h0, 3'd1, lat);
        checkOutput("stall latency", 32'(lat), 32'd3);
        held = resp_result;
        checkOutput("stall result", held, 32'h40C00000);
        req_valid = 1'b1; req_op = 3'd1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("stall%0d resp_valid", k), 32'(resp_valid), 32'd1);
            checkOutput($sformatf("stall%0d result", k), resp_result, 32'h40C00000);
            checkOutput($sformatf("stall%0d req_ready", k), 32'(req_ready), 32'd0);
        end
        checkOutput("stall unit_command idle", 32'(unit_command), 32'd0);
        checkOutput("stall unit_src2 idle", unit_src2, 32'd0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("release req_ready", 32'(req_ready), 32'd1);
        checkOutput("release resp_valid", 32'(resp_valid), 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("no accept during consume", 32'(req_ready), 32'd1);

        // Reset in the middle of a two-pass op discards it.
        req_valid = 1'b1; req_op = 3'd3;
        req_src1 = 32'h40000000; req_src2 = 32'h40400000; req_src3 = 32'h3F800000; req_rounding_mode = 3'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("mid reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("mid reset resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("mid reset rounding mode", 32'(unit_rounding_mode), 32'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (resp_valid) seen++;
            @(posedge clk); #1;
        end
        checkOutput("no response after reset", 32'(seen), 32'd0);
        runVector("post reset", vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].res, vecs[0].flags, vecs[0].lat);

        // PASS1 inexact product, PASS2 overflow: both flags must survive.
        begin
`ifdef FP_MUL_ADD_SEQUENCER_PERF_COUNT_EN
            automatic logic [31:0] ops0  = perf_ops;
            automatic logic [31:0] busy0 = perf_busy;
`endif
            expv = ref_model(3'd3, 32'h7F000001, 32'h3FC00001, 32'h7F000000);
            applyStimulus(3'd3, 32'h7F000001, 32'h3FC00001, 32'h7F000000, 3'd2, lat);
            checkOutput("flag merge latency", 32'(lat), 32'd5);
            checkOutput("flag merge NX OF", 32'(resp_flags & 5'b00101), 32'b00101);
            checkOutput("flag merge model", 32'(resp_flags), 32'(expv[36:32]));
            @(posedge clk); #1;
`ifdef FP_MUL_ADD_SEQUENCER_PERF_COUNT_EN
            checkOutput("perf_ops delta", perf_ops - ops0, 32'd1);
            checkOutput("perf_busy delta", perf_busy - busy0, 32'd5);
`endif
        end

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom);
            ra = rand_fp(); rb = rand_fp(); rc = rand_fp();
            expv = ref_model(rop, ra, rb, rc);
            runVector($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, rc, expv[31:0], expv[36:32], ref_latency(rop));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("%0d/%0d checks passed", checks_passed, checks_total + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fp_mul_add_sequencer.md
FP_MUL_ADD_SEQUENCER -- requirements
Module: fp_mul_add_sequencer

Interface
REQ-001 SHALL have parameter EXPONENT_WIDTH, default 8, exponent bits.
REQ-002 SHALL have parameter FRACTION_WIDTH, default 23, fraction bits.
REQ-003 SHALL have parameter WIDTH, default 1+EXPONENT_WIDTH+FRACTION_WIDTH, operand width.
REQ-004 SHALL have parameter UNIT_LATENCY, default 2, cycles per mul-add unit pass (>=1).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  request accepted this cycle if valid.
REQ-009 SHALL have port req_op  input  3  0 FMUL, 1 FADD, 2 FSUB, 3 FMADD, 4 FMSUB, 5 FNMSUB, 6 FNMADD, 7 reserved.
REQ-010 SHALL have ports req_src1, req_src2, req_src3  input  WIDTH each  operands a, b, c.
REQ-011 SHALL have port req_rounding_mode  input  3  RISC-V rm, passed to unit unchanged.
REQ-012 SHALL have port resp_valid  output  1  result available.
REQ-013 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-014 SHALL have ports resp_result  output  WIDTH, and resp_flags  output  5 (NV,DZ,OF,UF,NX).
REQ-015 SHALL have ports unit_command  output  2 (0 MUL, 1 ADD, 2 SUB), unit_src1/unit_src2  output  WIDTH, unit_rounding_mode  output  3.
REQ-016 SHALL have ports unit_result  input  WIDTH, unit_flags  input  5, sampled on last cycle of a pass.

Function
REQ-017 SHALL implement FSM states IDLE, PASS1, PASS2, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; acceptance on req_valid&&req_ready latches op, operands, rm.
REQ-019 Accept SHALL move IDLE->PASS1 (op 0-6) or IDLE->RESP (op 7).
REQ-020 Each pass SHALL hold unit inputs stable exactly UNIT_LATENCY cycles via down-counter; unit_result/unit_flags captured when counter reaches final cycle.
REQ-021 PASS1 SHALL issue: FMUL MUL(a,b); FADD ADD(a,b); FSUB SUB(a,b); ops 3-6 MUL(a,b).
REQ-022 After PASS1, ops 0-2 SHALL go to RESP; ops 3-6 SHALL go to PASS2 with p = PASS1 result.
REQ-023 PASS2 SHALL issue: FMADD ADD(p,c); FMSUB SUB(p,c); FNMSUB ADD(-p,c); FNMADD SUB(-p,c); -p flips bit WIDTH-1 only.
REQ-024 resp_flags SHALL be bitwise OR of flags of all passes of the operation.
REQ-025 Op 7 SHALL respond with canonical NaN (exponent all-ones, fraction MSB 1, else 0; 0x7FC00000 at defaults) and flags NV only.
REQ-026 Accept at cycle T SHALL give resp_valid at T+1+UNIT_LATENCY (single-pass), T+1+2*UNIT_LATENCY (two-pass), T+1 (op 7).
REQ-027 In RESP, resp_valid SHALL be 1 and result/flags stable until resp_valid&&resp_ready, then IDLE next cycle.
REQ-028 No new request SHALL be accepted in the cycle the response is consumed (req_ready=0 in RESP).
REQ-029 Outside PASS1/PASS2, unit_command, unit_src1, unit_src2 SHALL be 0; unit_rounding_mode SHALL be the latched rm.
REQ-030 Request inputs SHALL be ignored outside IDLE; changes after acceptance SHALL not affect the operation.

Reset
REQ-031 On rst=1 at a clock edge, state SHALL be IDLE, counter 0, latched regs 0, resp_valid 0, resp_result 0, resp_flags 0, req_ready 1 next cycle.
REQ-032 rst during PASS1/PASS2/RESP SHALL discard the operation with no response produced.
REQ-033 rst SHALL take priority over accept and response handshake in the same cycle.

Configuration
REQ-034 Macro FP_MUL_ADD_SEQUENCER_PERF_COUNT_EN defined SHALL add outputs perf_ops (32, ++ per consumed response) and perf_busy (32, ++ per cycle not IDLE), both zeroed by rst, wrapping at 2^32.
REQ-035 Without FP_MUL_ADD_SEQUENCER_PERF_COUNT_EN, perf ports and counters SHALL not exist; other behaviour identical.

Verification (UNIT_LATENCY=2, bench behavioural IEEE single unit model)
REQ-036 FMADD a=0x40000000 b=0x40400000 c=0x3F800000 accepted T -> resp_valid T+5, result 0x40E00000, flags 0.
REQ-037 FNMADD same operands -> result 0xC0E00000 at T+5; FMUL same a,b -> 0x40C00000 at T+3.
REQ-038 Op 7 accepted T -> resp_valid T+1, result 0x7FC00000, flags NV=1 others 0.
REQ-039 resp_ready held 0 for 4 cycles -> resp_valid and result stable, req_ready 0 throughout; release -> IDLE next cycle, req_ready 1.
REQ-040 rst asserted at T+3 of FMADD -> IDLE at T+4, resp_valid never asserted, next request completes normally.
REQ-041 FMADD where PASS1 sets NX and PASS2 sets OF -> resp_flags NX=1 and OF=1; with PERF_COUNT_EN, perf_ops +1 and perf_busy +5.
